// File: rtl/debayer_line_sequencer_pkg.sv
// Shared constants, FSM state type and one-hot helper for the debayer line-RAM sequencer.
package debayer_pkg;

    localparam int unsigned NUM_LINE_RAMS = 4;
    localparam int unsigned LINE_ADDR_W   = 10;
    localparam int unsigned LINE_CNT_W    = 12;
    localparam int unsigned MAX_WORDS     = 1024;
    localparam int unsigned PRIME_LINES   = 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_GAP,
        S_LINE
    } seq_state_e;

    function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
        logic [1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (oh[i]) begin
                idx = idx | 2'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/debayer_line_sequencer_if.sv
// Framing inputs and RAM-control outputs of the line sequencer, bundled for the datapath boundary.
interface debayer_line_sequencer_if #(
    parameter int unsigned ADDR_W = debayer_pkg::LINE_ADDR_W,
    parameter int unsigned CNT_W  = debayer_pkg::LINE_CNT_W
);
    logic              frame_valid_i;
    logic              line_valid_i;
    logic              data_valid_i;
    logic [3:0]        wr_sel_o;
    logic              wr_en_o;
    logic [1:0]        rd_index_o;
    logic [ADDR_W-1:0] addr_o;
    logic [CNT_W-1:0]  line_count_o;
    logic              row_parity_o;
    logic              out_enable_o;
    logic              line_start_o;
    logic              overflow_o;
    logic              proto_err_o;

    modport master (
        output frame_valid_i, line_valid_i, data_valid_i,
        input  wr_sel_o, wr_en_o, rd_index_o, addr_o, line_count_o,
        input  row_parity_o, out_enable_o, line_start_o, overflow_o, proto_err_o
    );

    modport slave (
        input  frame_valid_i, line_valid_i, data_valid_i,
        output wr_sel_o, wr_en_o, rd_index_o, addr_o, line_count_o,
        output row_parity_o, out_enable_o, line_start_o, overflow_o, proto_err_o
    );
endinterface

// File: rtl/debayer_line_sequencer_rotator.sv
// Write-select / read-centre rotation across the four line RAMs.
module line_ram_rotator
    import debayer_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       load_i,
    input  logic       advance_i,
    output logic [3:0] wr_sel_o,
    output logic [1:0] rd_index_o
);

    logic [3:0] wr_sel_q, wr_sel_d;
    logic [1:0] rd_q, rd_d;

    // Read centre is derived from the write select so the written RAM can never enter the window.
    always_comb begin
        wr_sel_d = wr_sel_q;
        if (load_i) begin
            wr_sel_d = 4'b1000;
        end else if (advance_i) begin
            wr_sel_d = {wr_sel_q[2:0], wr_sel_q[3]};
        end
        rd_d = onehot_to_idx(wr_sel_d) + 2'd2;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_sel_q <= 4'b1000;
            rd_q     <= 2'd1;
        end else begin
            wr_sel_q <= wr_sel_d;
            rd_q     <= rd_d;
        end
    end

    assign wr_sel_o   = wr_sel_q;
    assign rd_index_o = rd_q;

endmodule

// File: rtl/debayer_line_sequencer.sv
// Line-RAM bank controller: frame/line FSM, shared address counter, line count and sticky error flags.
module debayer_line_sequencer #(
    parameter int unsigned NUM_LINE_RAMS = debayer_pkg::NUM_LINE_RAMS,
    parameter int unsigned ADDR_W        = debayer_pkg::LINE_ADDR_W,
    parameter int unsigned LINE_CNT_W    = debayer_pkg::LINE_CNT_W,
    parameter int unsigned MAX_WORDS     = debayer_pkg::MAX_WORDS,
    parameter int unsigned PRIME_LINES   = debayer_pkg::PRIME_LINES
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    debayer_line_sequencer_if.slave  bus
);
    import debayer_pkg::*;

    localparam int unsigned WCNT_W = ADDR_W + 1;
    localparam logic [WCNT_W-1:0] MAX_CNT  = WCNT_W'(MAX_WORDS);
    localparam logic [WCNT_W-1:0] ADDR_TOP = WCNT_W'((1 << ADDR_W) - 1);

    seq_state_e              state_q, state_d;
    logic                    fv_q, lv_q;
    logic [WCNT_W-1:0]       wcnt_q, wcnt_d;
    logic [LINE_CNT_W-1:0]   line_cnt_q, line_cnt_d;
    logic                    out_en_q, line_start_q, ovf_q, perr_q;
    logic                    fv_rise, fv_fall, lv_rise, lv_fall;
    logic                    frame_start, line_accept, word_try, wr_en, ovf_hit, err_now;
    logic [NUM_LINE_RAMS-1:0] wr_sel;
    logic [1:0]              rd_index;

    always_comb begin
        fv_rise     = bus.frame_valid_i & ~fv_q;
        fv_fall     = ~bus.frame_valid_i & fv_q;
        lv_rise     = bus.line_valid_i & ~lv_q;
        lv_fall     = ~bus.line_valid_i & lv_q;
        frame_start = (state_q == S_ARM) & fv_rise;
        line_accept = (state_q == S_GAP) & lv_rise & ~fv_fall;
        word_try    = bus.data_valid_i & (state_q == S_LINE) & ~lv_rise;
        wr_en       = word_try & (wcnt_q < MAX_CNT);
        ovf_hit     = word_try & (wcnt_q >= MAX_CNT);
        err_now     = (lv_rise & ~fv_fall & ((state_q == S_IDLE) | (state_q == S_ARM)))
                    | (bus.data_valid_i & ((state_q != S_LINE) | lv_rise));
    end

    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        line_cnt_d = line_cnt_q;
        unique case (state_q)
            S_IDLE: if (!fv_q) state_d = S_ARM;
            S_ARM: begin
                if (fv_rise) begin
                    state_d    = S_GAP;
                    line_cnt_d = '0;
                end
            end
            S_GAP: begin
                if (fv_fall) begin
                    state_d = S_ARM;
                    wcnt_d  = '0;
                end else if (lv_rise) begin
                    state_d = S_LINE;
                    if (line_cnt_q != '1) line_cnt_d = line_cnt_q + LINE_CNT_W'(1);
                end
            end
            S_LINE: begin
                if (fv_fall || lv_fall) begin
                    state_d = fv_fall ? S_ARM : S_GAP;
                    wcnt_d  = '0;
                end else if (wr_en) begin
                    wcnt_d = wcnt_q + WCNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // fv_q resets high so a frame already running at reset release is never mistaken for a start.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            fv_q         <= 1'b1;
            lv_q         <= 1'b0;
            wcnt_q       <= '0;
            line_cnt_q   <= '0;
            out_en_q     <= 1'b0;
            line_start_q <= 1'b0;
            ovf_q        <= 1'b0;
            perr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            fv_q         <= bus.frame_valid_i;
            lv_q         <= bus.line_valid_i;
            wcnt_q       <= wcnt_d;
            line_cnt_q   <= line_cnt_d;
            out_en_q     <= (state_d == S_LINE) & (line_cnt_d >= LINE_CNT_W'(PRIME_LINES));
            line_start_q <= line_accept;
            ovf_q        <= (frame_start ? 1'b0 : ovf_q) | ovf_hit;
            perr_q       <= (frame_start ? 1'b0 : perr_q) | err_now;
        end
    end

    line_ram_rotator u_rotator (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .load_i     (frame_start),
        .advance_i  (line_accept),
        .wr_sel_o   (wr_sel),
        .rd_index_o (rd_index)
    );

    // A full line (MAX_WORDS == 2**ADDR_W) cannot be shown in ADDR_W bits, so the port pins at the top address.
    assign bus.addr_o       = (wcnt_q > ADDR_TOP) ? '1 : wcnt_q[ADDR_W-1:0];
    assign bus.wr_sel_o     = wr_sel;
    assign bus.rd_index_o   = rd_index;
    assign bus.wr_en_o      = wr_en;
    assign bus.line_count_o = line_cnt_q;
    assign bus.row_parity_o = line_cnt_q[0];
    assign bus.out_enable_o = out_en_q;
    assign bus.line_start_o = line_start_q;
    assign bus.overflow_o   = ovf_q;
    assign bus.proto_err_o  = perr_q;

endmodule

// File: tb/tb_debayer_line_sequencer.sv
// Self-checking bench: line-start scoreboard fed from a vector table, plus directed framing corner cases.
module tb_debayer_line_sequencer;
    import debayer_pkg::*;

    localparam int unsigned AW = LINE_ADDR_W;
    localparam int unsigned CW = LINE_CNT_W;
    localparam int unsigned MW = MAX_WORDS;
    localparam int unsigned ADDR_CLIP = (MW > (1 << AW) - 1) ? (1 << AW) - 1 : MW;

    typedef struct {
        int unsigned nwords;
        logic [3:0]  wr_sel;
        logic [1:0]  rd;
        logic        par;
        logic        oe;
    } line_vec_t;

    logic clk = 1'b0;
    logic reset_i;
    always #5 clk = ~clk;

    debayer_line_sequencer_if #(.ADDR_W(AW), .CNT_W(CW)) sif ();

    debayer_line_sequencer #(
        .ADDR_W     (AW),
        .LINE_CNT_W (CW),
        .MAX_WORDS  (MW)
    ) dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .bus     (sif)
    );

    line_vec_t   sb_q[$];
    line_vec_t   t1[4];
    line_vec_t   v;
    int unsigned tests = 0;
    int unsigned fails = 0;
    int unsigned wr_cnt = 0;
    int unsigned ls_cnt = 0;
    bit          sb_en = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] exp_rd(input logic [3:0] ws);
        case (ws)
            4'b0001: return 2'd2;
            4'b0010: return 2'd3;
            4'b0100: return 2'd0;
            4'b1000: return 2'd1;
            default: return 2'bxx;
        endcase
    endfunction

    always @(negedge clk) begin : mon
        line_vec_t e;
        if (reset_i === 1'b0) begin
            if (sif.wr_en_o === 1'b1) wr_cnt++;
            check("rd window invariant", 32'(sif.rd_index_o), 32'(exp_rd(sif.wr_sel_o)));
            if (sif.line_start_o === 1'b1) begin
                ls_cnt++;
                if (sb_en) begin
                    if (sb_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL line_start: got unexpected pulse, expected none");
                    end else begin
                        e = sb_q.pop_front();
                        check("line_start {wr_sel,rd,par,oe}",
                              32'({sif.wr_sel_o, sif.rd_index_o, sif.row_parity_o, sif.out_enable_o}),
                              32'({e.wr_sel, e.rd, e.par, e.oe}));
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " wr_sel"}, 32'(sif.wr_sel_o), 32'h8);
        check({tag, " rd_index"}, 32'(sif.rd_index_o), 32'd1);
        check({tag, " addr"}, 32'(sif.addr_o), 32'd0);
        check({tag, " line_count"}, 32'(sif.line_count_o), 32'd0);
        check({tag, " flags"}, 32'({sif.row_parity_o, sif.out_enable_o, sif.line_start_o,
                                    sif.overflow_o, sif.proto_err_o, sif.wr_en_o}), 32'd0);
    endtask

    task automatic send_line(input int unsigned nwords, input bit dv_on_rise,
                             input int unsigned exp_addr, input string tag);
        sif.line_valid_i = 1'b1;
        sif.data_valid_i = dv_on_rise;
        tick();
        for (int unsigned i = 0; i < nwords; i++) begin
            sif.data_valid_i = 1'b1;
            tick();
        end
        sif.data_valid_i = 1'b0;
        check({tag, " addr at line end"}, 32'(sif.addr_o), 32'(exp_addr));
        sif.line_valid_i = 1'b0;
        tick();
        check({tag, " addr after lv fall"}, 32'(sif.addr_o), 32'd0);
        check({tag, " out_enable after lv fall"}, 32'(sif.out_enable_o), 32'd0);
        tick();
    endtask

    task automatic frame_begin();
        sif.frame_valid_i = 1'b1;
        tick();
    endtask

    task automatic frame_end();
        sif.frame_valid_i = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1);
    end

    initial begin
        t1[0] = '{nwords: 8, wr_sel: 4'b0001, rd: 2'd2, par: 1'b1, oe: 1'b0};
        t1[1] = '{nwords: 8, wr_sel: 4'b0010, rd: 2'd3, par: 1'b0, oe: 1'b0};
        t1[2] = '{nwords: 8, wr_sel: 4'b0100, rd: 2'd0, par: 1'b1, oe: 1'b1};
        t1[3] = '{nwords: 8, wr_sel: 4'b1000, rd: 2'd1, par: 1'b0, oe: 1'b1};

        sif.frame_valid_i = 1'b0;
        sif.line_valid_i  = 1'b0;
        sif.data_valid_i  = 1'b0;
        reset_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("reset");
        reset_i = 1'b0;
        repeat (3) tick();

        // T1: four lines, table-driven
        frame_begin();
        check("T1 frame start wr_sel", 32'(sif.wr_sel_o), 32'h8);
        wr_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            sb_q.push_back(t1[i]);
            send_line(t1[i].nwords, 1'b0, t1[i].nwords, "T1");
        end
        check("T1 wr_en count", wr_cnt, 32'd32);
        check("T1 line_count", 32'(sif.line_count_o), 32'd4);
        check("T1 proto_err", 32'(sif.proto_err_o), 32'd0);

        // T2: overlong line
        v = '{nwords: MW + 3, wr_sel: 4'b0001, rd: 2'd2, par: 1'b1, oe: 1'b1};
        sb_q.push_back(v);
        wr_cnt = 0;
        send_line(MW + 3, 1'b0, ADDR_CLIP, "T2");
        check("T2 wr_en count", wr_cnt, 32'(MW));
        check("T2 overflow", 32'(sif.overflow_o), 32'd1);
        frame_end();
        check("T2 overflow sticky past fv fall", 32'(sif.overflow_o), 32'd1);
        frame_begin();
        check("T2 overflow cleared at fv rise", 32'(sif.overflow_o), 32'd0);
        check("T2 line_count cleared", 32'(sif.line_count_o), 32'd0);

        // T3: data coincident with line start
        check("T3 proto_err before", 32'(sif.proto_err_o), 32'd0);
        v = '{nwords: 0, wr_sel: 4'b0001, rd: 2'd2, par: 1'b1, oe: 1'b0};
        sb_q.push_back(v);
        wr_cnt = 0;
        send_line(0, 1'b1, 0, "T3");
        check("T3 proto_err", 32'(sif.proto_err_o), 32'd1);
        check("T3 wr_en count", wr_cnt, 32'd0);

        // T4: reset released inside a frame
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        ls_cnt = 0;
        wr_cnt = 0;
        for (int i = 0; i < 3; i++) send_line(4, 1'b0, 0, "T4");
        check("T4 line_start pulses", ls_cnt, 32'd0);
        check("T4 wr_sel held", 32'(sif.wr_sel_o), 32'h8);
        check("T4 wr_en count", wr_cnt, 32'd0);
        frame_end();
        frame_begin();
        v = '{nwords: 4, wr_sel: 4'b0001, rd: 2'd2, par: 1'b1, oe: 1'b0};
        sb_q.push_back(v);
        send_line(4, 1'b0, 4, "T4 next frame");

        // T5: frame ends inside an open line
        v = '{nwords: 5, wr_sel: 4'b0010, rd: 2'd3, par: 1'b0, oe: 1'b0};
        sb_q.push_back(v);
        sif.line_valid_i = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            sif.data_valid_i = 1'b1;
            tick();
        end
        sif.data_valid_i = 1'b0;
        check("T5 addr before fv fall", 32'(sif.addr_o), 32'd5);
        sif.frame_valid_i = 1'b0;
        tick();
        check("T5 addr after fv fall", 32'(sif.addr_o), 32'd0);
        check("T5 out_enable after fv fall", 32'(sif.out_enable_o), 32'd0);
        check("T5 state after fv fall", 32'(dut.state_q), 32'(S_ARM));
        sif.line_valid_i  = 1'b0;
        sif.frame_valid_i = 1'b1;
        tick();
        v = '{nwords: 2, wr_sel: 4'b0001, rd: 2'd2, par: 1'b1, oe: 1'b0};
        sb_q.push_back(v);
        send_line(2, 1'b0, 2, "T5 restart");

        // T6: asynchronous reset mid-line
        v = '{nwords: 3, wr_sel: 4'b0010, rd: 2'd3, par: 1'b0, oe: 1'b0};
        sb_q.push_back(v);
        sif.line_valid_i = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            sif.data_valid_i = 1'b1;
            tick();
        end
        check("T6 addr before reset", 32'(sif.addr_o), 32'd3);
        #2;
        reset_i = 1'b1;
        #1;
        check_reset_vals("T6 async reset");
        sif.line_valid_i = 1'b0;
        sif.data_valid_i = 1'b0;
        tick();
        reset_i = 1'b0;

        // Random framing with the window invariant checked every cycle
        sb_en = 1'b0;
        sif.frame_valid_i = 1'b0;
        repeat (3) tick();
        for (int unsigned c = 0; c < 600; c++) begin
            if ($urandom_range(0, 39) == 0) sif.frame_valid_i = ~sif.frame_valid_i;
            if ($urandom_range(0, 7) == 0) sif.line_valid_i = ~sif.line_valid_i;
            sif.data_valid_i = (sif.line_valid_i & ($urandom_range(0, 1) == 1))
                             | ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 249) == 0) begin
                reset_i = 1'b1;
                #1;
                reset_i = 1'b0;
            end
            tick();
        end
        sif.frame_valid_i = 1'b0;
        sif.line_valid_i  = 1'b0;
        sif.data_valid_i  = 1'b0;
        tick();
        check("scoreboard drained", sb_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
